// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture path.
package i2s_pkg;

  typedef enum logic {
    I2S_SYNC = 1'b0,
    I2S_RUN  = 1'b1
  } i2s_state_e;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  localparam int unsigned I2S_WIDTH_DEF = 16;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a third stage for
// rising-edge detection; rise_c is high for one clk cycle per input rise.
module i2s_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_c
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

endmodule

// File: rtl/i2s_capture.sv
// I2S receiver: oversamples bclk/lrclk/din with clk and delivers stereo PCM words.
// Optional link-loss detection is enabled with I2S_CAPTURE_TIMEOUT_EN.
module i2s_capture
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = I2S_WIDTH_DEF
`ifdef I2S_CAPTURE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i2s_bclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_din,
  output logic [WIDTH-1:0] audio_l,
  output logic [WIDTH-1:0] audio_r,
  output logic             sample_valid,
  output logic             frame_err
`ifdef I2S_CAPTURE_TIMEOUT_EN
  , output logic           link_lost
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             bclk_rise;
  logic             lr_s1, lr_s2, din_s1, din_s2;
  logic             timeout_c;

  i2s_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lr_prev_q, lr_prev_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic             have_l_q, have_l_d;
  logic [WIDTH-1:0] audio_l_d, audio_r_d;
  logic             sample_valid_d, frame_err_d;

  logic [WIDTH-1:0] shreg_app;
  logic [CNT_W-1:0] n_app;
  logic [WIDTH-1:0] word_c;

  i2s_sync_edge u_bclk_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (i2s_bclk),
    .rise_c   (bclk_rise)
  );

  // lrclk and din use the same depth as the bclk s2 tap to stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      lr_s1  <= 1'b0;
      lr_s2  <= 1'b0;
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
    end else begin
      lr_s1  <= i2s_lrclk;
      lr_s2  <= lr_s1;
      din_s1 <= i2s_din;
      din_s2 <= din_s1;
    end
  end

`ifdef I2S_CAPTURE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;

  assign timeout_c = !bclk_rise && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      link_lost <= 1'b0;
    end else if (bclk_rise) begin
      to_cnt_q  <= '0;
      link_lost <= 1'b0;
    end else begin
      if (to_cnt_q != TO_W'(TIMEOUT_CYCLES))
        to_cnt_q <= to_cnt_q + TO_W'(1);
      if (timeout_c)
        link_lost <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= I2S_SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_c)
      state_d = I2S_SYNC;
    else if (bclk_rise && (state_q == I2S_SYNC) && (lr_s2 != lr_prev_q))
      state_d = I2S_RUN;
  end

  // Current bit appended (saturating at WIDTH) and the left-aligned word it would finalize
  assign shreg_app = (count_q < CNT_W'(WIDTH)) ? {shreg_q[WIDTH-2:0], din_s2} : shreg_q;
  assign n_app     = (count_q < CNT_W'(WIDTH)) ? count_q + CNT_W'(1) : count_q;
  assign word_c    = shreg_app << (CNT_W'(WIDTH) - n_app);

  always_comb begin
    shreg_d        = shreg_q;
    count_d        = count_q;
    lr_prev_d      = lr_prev_q;
    hold_l_d       = hold_l_q;
    have_l_d       = have_l_q;
    audio_l_d      = audio_l;
    audio_r_d      = audio_r;
    sample_valid_d = 1'b0;
    frame_err_d    = 1'b0;

    if (bclk_rise) begin
      lr_prev_d = lr_s2;
      if (state_q == I2S_SYNC) begin
        if (lr_s2 != lr_prev_q) begin
          shreg_d = '0;
          count_d = '0;
        end
      end else if (lr_s2 == lr_prev_q) begin
        shreg_d = shreg_app;
        count_d = n_app;
      end else begin
        shreg_d     = '0;
        count_d     = '0;
        frame_err_d = (n_app < CNT_W'(WIDTH));
        if (lr_prev_q == I2S_LEFT) begin
          hold_l_d = word_c;
          have_l_d = 1'b1;
        end else if (have_l_q) begin
          audio_l_d      = hold_l_q;
          audio_r_d      = word_c;
          sample_valid_d = 1'b1;
          have_l_d       = 1'b0;
        end
      end
    end

    // Link loss drops partial data and blanks the outputs
    if (timeout_c) begin
      shreg_d   = '0;
      count_d   = '0;
      have_l_d  = 1'b0;
      audio_l_d = '0;
      audio_r_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q      <= '0;
      count_q      <= '0;
      lr_prev_q    <= 1'b0;
      hold_l_q     <= '0;
      have_l_q     <= 1'b0;
      audio_l      <= '0;
      audio_r      <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      lr_prev_q    <= lr_prev_d;
      hold_l_q     <= hold_l_d;
      have_l_q     <= have_l_d;
      audio_l      <= audio_l_d;
      audio_r      <= audio_r_d;
      sample_valid <= sample_valid_d;
      frame_err    <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_i2s_capture.sv
// Self-checking bench for i2s_capture: word-level reference model, random I2S streams.
module tb_i2s_capture;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 4096;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i2s_bclk = 1'b0;
  logic         i2s_lrclk = 1'b0;
  logic         i2s_din = 1'b0;
  logic [W-1:0] audio_l, audio_r;
  logic         sample_valid, frame_err;
`ifdef I2S_CAPTURE_TIMEOUT_EN
  logic         link_lost;
`endif

  i2s_capture #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_din      (i2s_din),
    .audio_l      (audio_l),
    .audio_r      (audio_r),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
`ifdef I2S_CAPTURE_TIMEOUT_EN
    , .link_lost  (link_lost)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Observed outputs
  logic [31:0] got_q[$];
  int unsigned got_cyc[$];
  int          fe_cnt = 0;
  int          stable_err = 0;
  logic [31:0] prev_audio = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (sample_valid) begin
        got_q.push_back({audio_l, audio_r});
        got_cyc.push_back(cyc);
      end else if ({audio_l, audio_r} !== prev_audio) begin
        stable_err++;
      end
      if (frame_err) fe_cnt++;
    end
    prev_audio = {audio_l, audio_r};
  end

  // Stream description: word values and bit lengths, channels alternate
  logic [31:0] wv[$];
  int          wl[$];
  logic [31:0] exp_q[$];
  int          exp_fe;
  int unsigned pin_cyc;

  function automatic logic [W-1:0] fit(input logic [31:0] v, input int k);
    logic [31:0] m;
    m = (k >= 32) ? v : (v & ((32'd1 << k) - 32'd1));
    if (k >= int'(W)) return W'(m >> (k - int'(W)));
    else              return W'(m << (int'(W) - k));
  endfunction

  // Word-level model: the first (partial or sync) word never produces output
  task automatic build_exp(input bit first_r, input int rst_slots);
    logic [W-1:0] hold, v;
    bit           have;
    int           eff;
    exp_q.delete();
    exp_fe = 0;
    have   = 0;
    hold   = '0;
    if (first_r) begin
      eff = wl[0] - rst_slots - 1;
      if (eff < int'(W)) exp_fe++;
    end
    for (int i = 1; i < wv.size(); i++) begin
      v = fit(wv[i], wl[i]);
      if (wl[i] < int'(W)) exp_fe++;
      if ((first_r ^ 1'(i & 1)) == 1'b0) begin
        hold = v;
        have = 1;
      end else if (have) begin
        exp_q.push_back({hold, v});
        have = 0;
      end
    end
  endtask

  // Drive the stream MSB first; lrclk leads data by one slot (Philips delay)
  task automatic play(input bit first_r, input int rst_slots);
    logic sd[$];
    logic sc[$];
    logic ch;
    for (int i = 0; i < wv.size(); i++) begin
      ch = first_r ^ 1'(i & 1);
      for (int b = wl[i] - 1; b >= 0; b--) begin
        sd.push_back(wv[i][b]);
        sc.push_back(ch);
      end
    end
    @(negedge clk);
    for (int j = 0; j < sd.size(); j++) begin
      reset     = (j < rst_slots);
      i2s_bclk  = 1'b0;
      i2s_lrclk = (j + 1 < sd.size()) ? sc[j+1] : ~sc[j];
      i2s_din   = sd[j];
      repeat (8) @(negedge clk);
      i2s_bclk = 1'b1;
      pin_cyc  = cyc;
      repeat (8) @(negedge clk);
    end
    reset    = 1'b0;
    i2s_bclk = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    fe_cnt     = 0;
    stable_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    i2s_bclk  = 1'b0;
    i2s_lrclk = 1'b0;
    i2s_din   = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_obs();
  endtask

  task automatic compare(input string name);
    check({name, ".n_samples"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({name, ".sample"}, 64'(got_q[i]), 64'(exp_q[i]));
    check({name, ".frame_err_cnt"}, 64'(fe_cnt), 64'(exp_fe));
    check({name, ".stable"}, 64'(stable_err), 64'd0);
  endtask

  function automatic int rand_len();
    int p;
    p = int'($urandom_range(0, 21));
    if (p <= 19) return p + 1;
    else if (p == 20) return 24;
    else return 32;
  endfunction

  task automatic set4(input logic [31:0] a, input int la, input logic [31:0] b, input int lb,
                      input logic [31:0] c, input int lc, input logic [31:0] d, input int ld);
    wv.delete(); wl.delete();
    wv.push_back(a); wl.push_back(la);
    wv.push_back(b); wl.push_back(lb);
    wv.push_back(c); wl.push_back(lc);
    wv.push_back(d); wl.push_back(ld);
  endtask

  initial begin
    // Reset with inputs toggling: no pulses, outputs zero
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i2s_bclk  = 1'($urandom);
      i2s_lrclk = 1'($urandom);
      i2s_din   = 1'($urandom);
      if (i > 0) begin
        check("reset.sample_valid", 64'(sample_valid), 64'd0);
        check("reset.frame_err", 64'(frame_err), 64'd0);
      end
    end
    check("reset.audio_l", 64'(audio_l), 64'd0);
    check("reset.audio_r", 64'(audio_r), 64'd0);
`ifdef I2S_CAPTURE_TIMEOUT_EN
    check("reset.link_lost", 64'(link_lost), 64'd0);
`endif
    do_reset();

    // Nominal frame after one sync frame, plus latency from the right-LSB pin rise
    set4($urandom, 16, $urandom, 16, 32'h8001, 16, 32'h7FFE, 16);
    build_exp(1'b0, 0);
    play(1'b0, 0);
    compare("nominal");
    check("nominal.latency", 64'(got_cyc.size() > 0 ? got_cyc[0] - pin_cyc : 32'hFFFF_FFFF), 64'd3);

    // Wide source: 32 bits per channel, truncated to the top 16
    do_reset();
    set4($urandom, 32, $urandom, 32, 32'h1234_5678, 32, 32'hCAFE_BABE, 32);
    build_exp(1'b0, 0);
    play(1'b0, 0);
    compare("wide");
    check("wide.l", 64'(audio_l), 64'h1234);
    check("wide.r", 64'(audio_r), 64'hCAFE);

    // Reset after data clears the outputs
    do_reset();
    check("rereset.audio_l", 64'(audio_l), 64'd0);
    check("rereset.audio_r", 64'(audio_r), 64'd0);

    // Short left word: zero-padded and flagged
    set4($urandom, 16, $urandom, 16, 32'hABC, 12, 32'h0F0F, 16);
    build_exp(1'b0, 0);
    play(1'b0, 0);
    compare("short");
    check("short.l", 64'(audio_l), 64'hABC0);
    check("short.r", 64'(audio_r), 64'h0F0F);

    // Reset released part-way through a right word
    do_reset();
    wv.delete(); wl.delete();
    wv.push_back($urandom); wl.push_back(16);
    wv.push_back($urandom); wl.push_back(16);
    wv.push_back($urandom); wl.push_back(16);
    build_exp(1'b1, 5);
    play(1'b1, 5);
    compare("midframe");

    // Random streams with mixed word lengths, including single-bit words
    for (int s = 0; s < 4; s++) begin
      int nw;
      do_reset();
      wv.delete(); wl.delete();
      nw = int'($urandom_range(6, 9));
      for (int i = 0; i < nw; i++) begin
        wv.push_back($urandom);
        wl.push_back(rand_len());
      end
      build_exp(1'b0, 0);
      play(1'b0, 0);
      compare("random");
    end

`ifdef I2S_CAPTURE_TIMEOUT_EN
    // Link loss after bclk stops, then recovery on the next full frame
    begin
      int unsigned lost_cyc;
      bit          seen;
      do_reset();
      set4($urandom, 16, $urandom, 16, $urandom, 16, $urandom, 16);
      build_exp(1'b0, 0);
      play(1'b0, 0);
      compare("pre_timeout");
      check("pre_timeout.link_lost", 64'(link_lost), 64'd0);
      seen = 0;
      lost_cyc = 0;
      for (int k = 0; k < int'(TO) + 100 && !seen; k++) begin
        @(negedge clk);
        if (link_lost) begin
          seen = 1;
          lost_cyc = cyc;
        end
      end
      check("timeout.link_lost", 64'(seen), 64'd1);
      // counted from the clk edge that registers the detected rise
      check("timeout.cycles", 64'(lost_cyc - pin_cyc - 3), 64'(TO));
      check("timeout.audio_l", 64'(audio_l), 64'd0);
      check("timeout.audio_r", 64'(audio_r), 64'd0);
      clear_obs();
      set4($urandom, 16, $urandom, 16, $urandom, 16, $urandom, 16);
      build_exp(1'b0, 0);
      play(1'b0, 0);
      compare("recover");
      check("recover.link_lost", 64'(link_lost), 64'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
